// File: rtl/fdma_read_arbiter.sv
// Burst-granular arbiter sharing one FDMA read port between two uidbuf read channels.
// Define FDMA_ARB_FIXED_PRIO_EN for fixed priority (ch0 wins); default is round-robin.
module fdma_read_arbiter #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 23,
    parameter int REQ_TIMEOUT    = 1024
) (
    input  logic                      ui_clk,
    input  logic                      ui_rst,
    input  logic [AXI_ADDR_WIDTH-1:0] m0_raddr,
    input  logic                      m0_rareq,
    input  logic [15:0]               m0_rsize,
    output logic                      m0_rbusy,
    output logic [AXI_DATA_WIDTH-1:0] m0_rdata,
    output logic                      m0_rvalid,
    input  logic [AXI_ADDR_WIDTH-1:0] m1_raddr,
    input  logic                      m1_rareq,
    input  logic [15:0]               m1_rsize,
    output logic                      m1_rbusy,
    output logic [AXI_DATA_WIDTH-1:0] m1_rdata,
    output logic                      m1_rvalid,
    output logic [AXI_ADDR_WIDTH-1:0] fdma_raddr,
    output logic                      fdma_rareq,
    output logic [15:0]               fdma_rsize,
    input  logic                      fdma_rbusy,
    input  logic [AXI_DATA_WIDTH-1:0] fdma_rdata,
    input  logic                      fdma_rvalid,
    output logic                      grant_id,
    output logic [1:0]                arb_err
);

    localparam int               TMO_W    = $clog2(REQ_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(REQ_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_BUSY
    } state_t;

    state_t                    state_q,      state_d;
    logic                      grant_q,      grant_d;
    logic                      last_grant_q, last_grant_d;
    logic [AXI_ADDR_WIDTH-1:0] raddr_q,      raddr_d;
    logic [15:0]               rsize_q,      rsize_d;
    logic                      rareq_q,      rareq_d;
    logic [1:0]                rbusy_q,      rbusy_d;
    logic [1:0]                rvalid_q,     rvalid_d;
    logic [1:0]                arb_err_q,    arb_err_d;
    logic [AXI_DATA_WIDTH-1:0] m0_rdata_q,   m0_rdata_d;
    logic [AXI_DATA_WIDTH-1:0] m1_rdata_q,   m1_rdata_d;
    logic [15:0]               beat_cnt_q,   beat_cnt_d;
    logic [TMO_W-1:0]          tmo_cnt_q,    tmo_cnt_d;
    logic                      winner;

`ifdef FDMA_ARB_FIXED_PRIO_EN
    assign winner = m0_rareq ? 1'b0 : 1'b1;
`else
    // With both requesting, the channel not served last wins; otherwise the sole requester.
    assign winner = (m0_rareq && m1_rareq) ? ~last_grant_q : m1_rareq;
`endif

    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        raddr_d      = raddr_q;
        rsize_d      = rsize_q;
        rareq_d      = rareq_q;
        rbusy_d      = rbusy_q;
        rvalid_d     = 2'b00;
        arb_err_d    = arb_err_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        beat_cnt_d   = beat_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;

        case (state_q)
            S_IDLE: begin
                tmo_cnt_d = '0;
                if (m0_rareq || m1_rareq) begin
                    grant_d = winner;
                    raddr_d = winner ? m1_raddr : m0_raddr;
                    rsize_d = winner ? m1_rsize : m0_rsize;
                    rbusy_d = winner ? 2'b10 : 2'b01;
                    rareq_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (fdma_rbusy) begin
                    rareq_d    = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = S_BUSY;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rareq_d            = 1'b0;
                    arb_err_d[grant_q] = 1'b1;
                    rbusy_d            = 2'b00;
                    last_grant_d       = grant_q;
                    state_d            = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_BUSY: begin
                // A beat arriving with rbusy already low keeps us here one more cycle
                // so the channel's busy still covers its forwarded valid.
                if (fdma_rvalid) begin
                    beat_cnt_d        = beat_cnt_q + 1'b1;
                    rvalid_d[grant_q] = 1'b1;
                    if (grant_q) m1_rdata_d = fdma_rdata;
                    else         m0_rdata_d = fdma_rdata;
                end else if (!fdma_rbusy) begin
                    rbusy_d = 2'b00;
                    if (beat_cnt_q != rsize_q) arb_err_d[grant_q] = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            raddr_q      <= '0;
            rsize_q      <= '0;
            rareq_q      <= 1'b0;
            rbusy_q      <= 2'b00;
            rvalid_q     <= 2'b00;
            arb_err_q    <= 2'b00;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            beat_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            raddr_q      <= raddr_d;
            rsize_q      <= rsize_d;
            rareq_q      <= rareq_d;
            rbusy_q      <= rbusy_d;
            rvalid_q     <= rvalid_d;
            arb_err_q    <= arb_err_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            beat_cnt_q   <= beat_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign fdma_raddr = raddr_q;
    assign fdma_rsize = rsize_q;
    assign fdma_rareq = rareq_q;
    assign m0_rbusy   = rbusy_q[0];
    assign m1_rbusy   = rbusy_q[1];
    assign m0_rvalid  = rvalid_q[0];
    assign m1_rvalid  = rvalid_q[1];
    assign m0_rdata   = m0_rdata_q;
    assign m1_rdata   = m1_rdata_q;
    assign grant_id   = grant_q;
    assign arb_err    = arb_err_q;

endmodule
